// File: rtl/id_hazard_unit.sv
// id_hazard_unit: load-use bubble, memory-wait freeze, branch flush, mem timeout and stall/bubble counters
module id_hazard_unit #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       if_id_rs1,
  input  logic [4:0]       if_id_rs2,
  input  logic             if_id_uses_rs1,
  input  logic             if_id_uses_rs2,
  input  logic             id_ex_MemRead,
  input  logic [4:0]       id_ex_rd,
  input  logic             ex_mem_MemRead,
  input  logic             ex_mem_MemWrite,
  input  logic             dmem_ack,
  input  logic             ex_branch_taken,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             pipe_freeze,
  output logic             mem_wb_bubble,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] bubble_count
);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [1:0] RUN = 2'd0, WAIT = 2'd1, ERR = 2'd2;
  logic [1:0] state;
  logic [WW-1:0] wait_cnt;
  logic mem_op, stall_req, lu_hazard, freeze, branch, lu_bubble;
  always_comb begin
    mem_op          = ex_mem_MemRead | ex_mem_MemWrite;
    stall_req       = mem_op & ~dmem_ack;
    lu_hazard       = id_ex_MemRead & (id_ex_rd != 5'd0) &
                      ((if_id_uses_rs1 & (id_ex_rd == if_id_rs1)) |
                       (if_id_uses_rs2 & (id_ex_rd == if_id_rs2)));
    freeze          = ~rst & ((state == ERR) | stall_req);
    branch          = ~rst & ~freeze & ex_branch_taken;
    lu_bubble       = ~rst & ~freeze & ~ex_branch_taken & lu_hazard;
    pipe_freeze     = freeze;
    mem_wb_bubble   = freeze;
    pc_write        = ~freeze & ~lu_bubble;
    if_id_write     = ~freeze & ~lu_bubble;
    if_id_flush     = branch;
    id_ex_flush     = branch | lu_bubble;
    mem_timeout_err = ~rst & (state == ERR);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      wait_cnt     <= '0;
      stall_cycles <= '0;
      bubble_count <= '0;
    end else begin
      state        <= (state == RUN)  ? (stall_req ? WAIT : RUN) :
                      (state == WAIT) ? (dmem_ack ? RUN : (wait_cnt == WW'(TIMEOUT - 1) ? ERR : WAIT)) :
                      ERR;
      wait_cnt     <= (state == WAIT && !dmem_ack) ? wait_cnt + 1'b1 : '0;
      stall_cycles <= stall_cycles + CNT_W'(freeze && stall_cycles != '1);
      bubble_count <= bubble_count + CNT_W'(lu_bubble && bubble_count != '1);
    end
  end
endmodule

// File: tb/tb_id_hazard_unit.sv
// tb_id_hazard_unit: table-driven and sequence checks of id_hazard_unit with TIMEOUT=4, CNT_W=4
module tb_id_hazard_unit;
  logic clk = 0, rst = 1;
  logic [4:0] rs1, rs2, rd;
  logic u1, u2, idmr, mr, mw, ack, br;
  logic pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_freeze, mem_wb_bubble, mem_timeout_err;
  logic [3:0] stall_cycles, bubble_count;
  int n_vec = 0, n_bad = 0;

  id_hazard_unit #(.TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .if_id_rs1(rs1), .if_id_rs2(rs2),
    .if_id_uses_rs1(u1), .if_id_uses_rs2(u2), .id_ex_MemRead(idmr), .id_ex_rd(rd),
    .ex_mem_MemRead(mr), .ex_mem_MemWrite(mw), .dmem_ack(ack), .ex_branch_taken(br),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .pipe_freeze(pipe_freeze), .mem_wb_bubble(mem_wb_bubble),
    .mem_timeout_err(mem_timeout_err), .stall_cycles(stall_cycles), .bubble_count(bubble_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, idmr, mr, mw, ack, br;
    logic [6:0] exp;
  } vec_t;

  function automatic logic [6:0] outs();
    return {pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_freeze, mem_wb_bubble, mem_timeout_err};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic idle();
    rs1 = 0; rs2 = 0; rd = 0; u1 = 0; u2 = 0; idmr = 0; mr = 0; mw = 0; ack = 0; br = 0;
  endtask

  task automatic set_lu();
    idmr = 1; rd = 5'd5; rs2 = 5'd5; u2 = 1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    tick(1);
    rst = 0;
    #1;
  endtask

  vec_t tbl[13];

  initial begin
    tbl[0]  = '{"idle",          0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b1100000};
    tbl[1]  = '{"lu_rs2",        0, 5, 5, 0, 1, 1, 0, 0, 0, 0, 7'b0001000};
    tbl[2]  = '{"lu_rd0",        0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 7'b1100000};
    tbl[3]  = '{"lu_rs1",        7, 0, 7, 1, 0, 1, 0, 0, 0, 0, 7'b0001000};
    tbl[4]  = '{"rs1_unused",    7, 0, 7, 0, 0, 1, 0, 0, 0, 0, 7'b1100000};
    tbl[5]  = '{"not_load",      7, 0, 7, 1, 0, 0, 0, 0, 0, 0, 7'b1100000};
    tbl[6]  = '{"branch",        0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7'b1111000};
    tbl[7]  = '{"branch_lu",     0, 5, 5, 0, 1, 1, 0, 0, 0, 1, 7'b1111000};
    tbl[8]  = '{"load_wait",     0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 7'b0000110};
    tbl[9]  = '{"frz_br_lu",     0, 5, 5, 0, 1, 1, 0, 1, 0, 1, 7'b0000110};
    tbl[10] = '{"ack_first_lu",  0, 5, 5, 0, 1, 1, 1, 0, 1, 0, 7'b0001000};
    tbl[11] = '{"ack_first_br",  0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 7'b1111000};
    tbl[12] = '{"ack_no_memop",  0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 7'b1100000};

    // reset forces outputs whatever the inputs say
    idle(); mr = 1; br = 1; set_lu();
    rst = 1;
    #2 check("rst_outs", 16'(outs()), 16'(7'b1100000));
    tick(1);
    idle(); rst = 0; #1;
    check("rst_stall", 16'(stall_cycles), 16'd0);
    check("rst_bubble", 16'(bubble_count), 16'd0);

    // combinational table; inputs returned to idle before each edge
    foreach (tbl[i]) begin
      @(negedge clk);
      rs1 = tbl[i].rs1; rs2 = tbl[i].rs2; rd = tbl[i].rd; u1 = tbl[i].u1; u2 = tbl[i].u2;
      idmr = tbl[i].idmr; mr = tbl[i].mr; mw = tbl[i].mw; ack = tbl[i].ack; br = tbl[i].br;
      #1 check(tbl[i].name, 16'(outs()), 16'(tbl[i].exp));
      #1 idle();
    end

    // load-use counts one bubble; branch+lu counts none; rd=0 counts none
    do_reset();
    set_lu(); tick(1);
    idle(); #1;
    check("lu_bubble_cnt", 16'(bubble_count), 16'd1);
    set_lu(); br = 1; tick(1);
    idle(); set_lu(); rd = 0; rs2 = 0; tick(1);
    check("br_lu_rd0_cnt", 16'(bubble_count), 16'd1);
    idle();

    // 3-cycle memory wait, then ack frees the pipe
    do_reset();
    mr = 1;
    for (int c = 0; c < 3; c++) begin
      #1 check($sformatf("wait_frz%0d", c), 16'(outs()), 16'(7'b0000110));
      tick(1);
    end
    ack = 1; #1;
    check("wait_ack", 16'(outs()), 16'(7'b1100000));
    tick(1);
    idle(); #1;
    check("wait_stalls", 16'(stall_cycles), 16'd3);

    // load-use held across a freeze -> exactly one bubble, in the ack cycle
    do_reset();
    mr = 1; set_lu(); tick(2);
    ack = 1; #1;
    check("lu_after_frz", 16'(outs()), 16'(7'b0001000));
    tick(1);
    idle(); #1;
    check("lu_frz_bubble", 16'(bubble_count), 16'd1);
    check("lu_frz_stall", 16'(stall_cycles), 16'd2);

    // timeout: 1 RUN cycle + 4 WAIT cycles without ack -> ERR
    do_reset();
    mr = 1; tick(4);
    check("pre_timeout", 16'(mem_timeout_err), 16'd0);
    tick(1);
    check("timeout_err", 16'(mem_timeout_err), 16'd1);
    idle(); #1;
    check("err_frz", 16'(outs()), 16'(7'b0000111));
    tick(2);
    check("err_sticky", 16'(outs()), 16'(7'b0000111));
    rst = 1; #1;
    check("err_rst_outs", 16'(outs()), 16'(7'b1100000));
    tick(1);
    rst = 0; #1;
    check("err_rst_clear", 16'(outs()), 16'(7'b1100000));
    check("err_rst_stall", 16'(stall_cycles), 16'd0);

    // ack in the last allowed WAIT cycle wins
    do_reset();
    mr = 1; tick(4);
    ack = 1; tick(1);
    ack = 0; mr = 0; #1;
    check("late_ack_run", 16'(outs()), 16'(7'b1100000));
    mr = 1; tick(4);
    check("late_ack_cnt_clr", 16'(mem_timeout_err), 16'd0);
    tick(1);
    check("late_ack_retimeout", 16'(mem_timeout_err), 16'd1);

    // stall counter saturates at 15
    do_reset();
    idle(); mr = 1; tick(14);
    check("sat_14", 16'(stall_cycles), 16'd14);
    tick(6);
    check("sat_hold", 16'(stall_cycles), 16'd15);

    // reset on the 2nd WAIT cycle
    do_reset();
    idle(); mr = 1; tick(2);
    rst = 1; #1;
    check("midwait_rst_frz", 16'(pipe_freeze), 16'd0);
    tick(1);
    rst = 0; idle(); #1;
    check("midwait_stall", 16'(stall_cycles), 16'd0);
    check("midwait_outs", 16'(outs()), 16'(7'b1100000));
    mr = 1; tick(4);
    check("midwait_run_err0", 16'(mem_timeout_err), 16'd0);
    tick(1);
    check("midwait_run_err1", 16'(mem_timeout_err), 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
